// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM frame arbiter: command encodings,
// arbiter state encodings and the frame-buffer select bit helper.
package sdram_arb_pkg;

    localparam logic [1:0] CMD_RD  = 2'd0;
    localparam logic [1:0] CMD_WR  = 2'd1;
    localparam logic [1:0] CMD_REF = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_t;

    // Index of the address bit just above a frame: ceil(log2(frame_words)).
    function automatic int unsigned frame_sel_bit(input int unsigned frame_words);
        return $clog2(frame_words);
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh request generator. A free-running counter raises ref_pending
// once per REF_PERIOD clocks; a refresh accept clears it. If the period
// expires while a refresh is still pending, ref_overrun latches until reset.
module sdram_refresh_timer #(
    parameter int unsigned REF_PERIOD = 780
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic ref_clr,
    output logic ref_pending,
    output logic ref_overrun
);

    localparam int unsigned CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

    logic [CNT_W-1:0] ref_cnt;
    logic             ref_wrap;

    assign ref_wrap = (ref_cnt == CNT_W'(REF_PERIOD - 1));

    // Period counter, 0 .. REF_PERIOD-1.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ref_cnt <= '0;
        end else if (ref_wrap) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // Pending flag: a new period wins over a same-cycle clear so no request is lost.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ref_pending <= 1'b0;
        end else if (ref_wrap) begin
            ref_pending <= 1'b1;
        end else if (ref_clr) begin
            ref_pending <= 1'b0;
        end
    end

    // Sticky overrun: the previous refresh was never served within its period.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ref_overrun <= 1'b0;
        end else if (ref_wrap && ref_pending) begin
            ref_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Single-port SDRAM scheduler for camera write bursts, VGA read bursts and
// auto-refresh. One command in flight at a time; frame-linear burst addresses.
// Optional double buffering is enabled by defining SDRAM_ARB_PINGPONG_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | arbitrate: refresh > (write if read streak full) > read > write
// ST_ISSUE | cmd_valid high, type/address frozen until cmd_ready
// ST_BUSY  | burst running, busy flag up until cmd_done
module sdram_frame_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned REF_PERIOD  = 780,
    parameter int unsigned READ_MAX    = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    output logic              cmd_valid,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_ready,
    input  logic              cmd_done,
    output logic              wr_busy,
    output logic              rd_busy,
    output logic              ref_overrun
);

    localparam int unsigned PTR_W    = frame_sel_bit(FRAME_WORDS);
    localparam int unsigned STREAK_W = $clog2(READ_MAX + 1);

    arb_state_t          state;
    logic [PTR_W-1:0]    wr_addr;
    logic [PTR_W-1:0]    rd_addr;
    logic [PTR_W:0]      wr_sum;
    logic [PTR_W:0]      rd_sum;
    logic [PTR_W-1:0]    wr_nxt;
    logic [PTR_W-1:0]    rd_nxt;
    logic [STREAK_W-1:0] streak;
    logic                wr_buf;
    logic                rd_buf;
    logic [ADDR_W-1:0]   wr_word;
    logic [ADDR_W-1:0]   rd_word;
    logic                wr_busy_q;
    logic                rd_busy_q;
    logic                accept;
    logic                ref_pending;
    logic                ref_clr;
    logic                pick_valid;
    logic [1:0]          pick_type;
    logic [ADDR_W-1:0]   pick_addr;

    assign accept  = (state == ST_ISSUE) && cmd_valid && cmd_ready;
    assign ref_clr = accept && (cmd_type == CMD_REF);

    sdram_refresh_timer #(
        .REF_PERIOD (REF_PERIOD)
    ) u_ref_timer (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .ref_clr     (ref_clr),
        .ref_pending (ref_pending),
        .ref_overrun (ref_overrun)
    );

    // Pointer advance with wrap at the end of the frame.
    assign wr_sum = {1'b0, wr_addr} + (PTR_W + 1)'(BURST_LEN);
    assign rd_sum = {1'b0, rd_addr} + (PTR_W + 1)'(BURST_LEN);
    assign wr_nxt = (wr_sum >= (PTR_W + 1)'(FRAME_WORDS)) ? '0 : wr_sum[PTR_W-1:0];
    assign rd_nxt = (rd_sum >= (PTR_W + 1)'(FRAME_WORDS)) ? '0 : rd_sum[PTR_W-1:0];

    // Write pointer: frame start overrides a same-cycle post-accept step.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_addr <= '0;
        end else if (wr_frame_start) begin
            wr_addr <= '0;
        end else if (accept && (cmd_type == CMD_WR)) begin
            wr_addr <= wr_nxt;
        end
    end

    // Read pointer: frame start overrides a same-cycle post-accept step.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rd_addr <= '0;
        end else if (rd_frame_start) begin
            rd_addr <= '0;
        end else if (accept && (cmd_type == CMD_RD)) begin
            rd_addr <= rd_nxt;
        end
    end

`ifdef SDRAM_ARB_PINGPONG_EN
    // Buffer select: writer flips buffers per camera frame; reader takes the other one.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_buf <= 1'b0;
            rd_buf <= 1'b0;
        end else begin
            if (wr_frame_start) begin
                wr_buf <= ~wr_buf;
            end
            if (rd_frame_start) begin
                rd_buf <= wr_frame_start ? wr_buf : ~wr_buf;
            end
        end
    end
`else
    assign wr_buf = 1'b0;
    assign rd_buf = 1'b0;
`endif

    assign wr_word = ADDR_W'({wr_buf, wr_addr});
    assign rd_word = ADDR_W'({rd_buf, rd_addr});

    // Arbitration decision taken in IDLE.
    always_comb begin
        pick_valid = 1'b1;
        pick_type  = CMD_RD;
        pick_addr  = '0;
        if (ref_pending) begin
            pick_type = CMD_REF;
        end else if (wr_req && (streak >= STREAK_W'(READ_MAX))) begin
            pick_type = CMD_WR;
            pick_addr = wr_word;
        end else if (rd_req) begin
            pick_type = CMD_RD;
            pick_addr = rd_word;
        end else if (wr_req) begin
            pick_type = CMD_WR;
            pick_addr = wr_word;
        end else begin
            pick_valid = 1'b0;
        end
    end

    // Command sequencer with registered command and busy outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_RD;
            cmd_addr  <= '0;
            wr_busy_q <= 1'b0;
            rd_busy_q <= 1'b0;
            streak    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        cmd_type  <= pick_type;
                        cmd_addr  <= pick_addr;
                        cmd_valid <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        cmd_valid <= 1'b0;
                        rd_busy_q <= (cmd_type == CMD_RD);
                        wr_busy_q <= (cmd_type == CMD_WR);
                        state     <= ST_BUSY;
                        if (cmd_type == CMD_RD) begin
                            if (streak != STREAK_W'(READ_MAX)) begin
                                streak <= streak + 1'b1;
                            end
                        end else if (cmd_type == CMD_WR) begin
                            streak <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cmd_done) begin
                        wr_busy_q <= 1'b0;
                        rd_busy_q <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_valid <= 1'b0;
                    wr_busy_q <= 1'b0;
                    rd_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Busy drops in the same cycle the controller reports completion.
    assign wr_busy = wr_busy_q && !cmd_done;
    assign rd_busy = rd_busy_q && !cmd_done;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter. A responder process models the
// SDRAM controller (cmd_ready, cmd_done three cycles after accept) and logs
// every issued command; the main process checks the logged sequence.
// Extra double-buffer checks when SDRAM_ARB_PINGPONG_EN is defined.
module tb_sdram_frame_arbiter;
    import sdram_arb_pkg::*;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned BURST  = 256;
    localparam int unsigned FW     = 307200;
    localparam int unsigned RP     = 780;
    localparam int unsigned RMAX   = 4;
    localparam int unsigned LOG_N  = 4096;
`ifdef SDRAM_ARB_PINGPONG_EN
    localparam logic [31:0] BUF_STEP = 32'd524288;
`else
    localparam logic [31:0] BUF_STEP = 32'd0;
`endif

    logic              CLK = 1'b0;
    logic              RSTn = 1'b0;
    logic              wr_req = 1'b0;
    logic              rd_req = 1'b0;
    logic              wr_frame_start = 1'b0;
    logic              rd_frame_start = 1'b0;
    logic              cmd_ready = 1'b0;
    logic              cmd_done = 1'b0;
    logic              cmd_valid;
    logic [1:0]        cmd_type;
    logic [ADDR_W-1:0] cmd_addr;
    logic              wr_busy;
    logic              rd_busy;
    logic              ref_overrun;

    always #5 CLK = ~CLK;

    sdram_frame_arbiter #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST),
        .FRAME_WORDS (FW),
        .REF_PERIOD  (RP),
        .READ_MAX    (RMAX)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .wr_req         (wr_req),
        .rd_req         (rd_req),
        .wr_frame_start (wr_frame_start),
        .rd_frame_start (rd_frame_start),
        .cmd_valid      (cmd_valid),
        .cmd_type       (cmd_type),
        .cmd_addr       (cmd_addr),
        .cmd_ready      (cmd_ready),
        .cmd_done       (cmd_done),
        .wr_busy        (wr_busy),
        .rd_busy        (rd_busy),
        .ref_overrun    (ref_overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // controls owned by the main process
    logic ready_en = 1'b1;
    logic done_en  = 1'b1;

    // responder-owned state and command log
    logic [1:0]  log_t [LOG_N];
    logic [31:0] log_a [LOG_N];
    int          log_c [LOG_N];
    int          log_n = 0;
    int          cyc = 0;
    logic        in_burst = 1'b0;
    logic [1:0]  btype = 2'd0;
    int          done_cnt = 0;
    logic        prev_valid = 1'b0;

    initial begin : responder
        logic exp_rd, exp_wr;
        forever begin
            @(negedge CLK);
            if (!RSTn) begin
                in_burst   = 1'b0;
                done_cnt   = 0;
                prev_valid = 1'b0;
            end else begin
                exp_rd = in_burst && (btype == CMD_RD) && !cmd_done;
                exp_wr = in_burst && (btype == CMD_WR) && !cmd_done;
                chk("rd_busy", 32'(rd_busy), 32'(exp_rd));
                chk("wr_busy", 32'(wr_busy), 32'(exp_wr));
                if (cmd_done) in_burst = 1'b0;
                if (cmd_valid && !prev_valid && log_n < LOG_N) begin
                    log_t[log_n] = cmd_type;
                    log_a[log_n] = 32'(cmd_addr);
                    log_c[log_n] = cyc;
                    log_n++;
                end
                prev_valid = cmd_valid;
                if (cmd_valid && cmd_ready) begin
                    in_burst = 1'b1;
                    btype    = cmd_type;
                    done_cnt = 3;
                end
            end
            @(posedge CLK);
            #1;
            if (RSTn) cyc++;
            else cyc = 0;
            cmd_ready = ready_en;
            cmd_done  = 1'b0;
            if (RSTn && in_burst && done_en) begin
                if (done_cnt > 0) done_cnt--;
                else cmd_done = 1'b1;
            end
        end
    end

    int rd_idx = 0;

    task automatic next_cmd(input bit skip_ref, output logic [1:0] t,
                            output logic [31:0] a, output int c, output bit ok);
        bit found = 0;
        int guard;
        ok = 1'b1;
        t  = 2'b11;
        a  = '1;
        c  = 0;
        while (!found && ok) begin
            guard = 0;
            while (rd_idx >= log_n && guard < 400) begin
                @(negedge CLK);
                guard++;
            end
            if (rd_idx >= log_n) begin
                chk("cmd_timeout", 32'(log_n), 32'(rd_idx + 1));
                ok = 1'b0;
            end else begin
                t = log_t[rd_idx];
                a = log_a[rd_idx];
                c = log_c[rd_idx];
                rd_idx++;
                if (!(skip_ref && t == CMD_REF)) found = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        RSTn   = 1'b0;
        wr_req = 1'b0;
        rd_req = 1'b0;
        #1;
        chk("rst_valid", 32'(cmd_valid), 0);
        chk("rst_type", 32'(cmd_type), 0);
        chk("rst_addr", 32'(cmd_addr), 0);
        chk("rst_rd_busy", 32'(rd_busy), 0);
        chk("rst_wr_busy", 32'(wr_busy), 0);
        chk("rst_overrun", 32'(ref_overrun), 0);
        repeat (3) @(negedge CLK);
        rd_idx = log_n;
    endtask

    task automatic release_reset();
        @(negedge CLK);
        #1;
        RSTn = 1'b1;
    endtask

    task automatic pulse(input bit is_wr);
        @(negedge CLK);
        #1;
        if (is_wr) wr_frame_start = 1'b1;
        else       rd_frame_start = 1'b1;
        @(posedge CLK);
        #2;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge CLK);
            guard++;
        end
        chk("wait_cyc", 32'(cyc >= target), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0]  t;
        logic [31:0] a;
        int          c;
        bit          ok;
        int          i;
        int          n_ref;
        bit          got;
        logic [1:0]  pat_t [10];
        logic [31:0] pat_a [10];

        // ---- read-only stream: linear addresses, frame wrap, refresh preemption
        do_reset();
        ready_en = 1'b1;
        done_en  = 1'b1;
        rd_req   = 1'b1;
        release_reset();
        i = 0;
        n_ref = 0;
        ok = 1'b1;
        while (i <= 1200 && ok) begin
            next_cmd(1'b0, t, a, c, ok);
            if (ok) begin
                if (t == CMD_REF) begin
                    if (n_ref == 0) begin
                        chk("ref_first_cyc_lo", 32'(c >= 781), 1);
                        chk("ref_first_cyc_hi", 32'(c <= 790), 1);
                        chk("ref_addr", a, 0);
                    end
                    n_ref++;
                end else begin
                    chk("rd_type", 32'(t), 32'(CMD_RD));
                    chk("rd_addr", a, 32'((i % 1200) * 256));
                    i++;
                end
            end
        end
        chk("ref_count_min", 32'(n_ref >= 5), 1);

        // ---- read and write both pending: R,R,R,R,W pattern
        do_reset();
        rd_req = 1'b1;
        wr_req = 1'b1;
        release_reset();
        pat_t[0] = CMD_RD; pat_a[0] = 32'd0;
        pat_t[1] = CMD_RD; pat_a[1] = 32'd256;
        pat_t[2] = CMD_RD; pat_a[2] = 32'd512;
        pat_t[3] = CMD_RD; pat_a[3] = 32'd768;
        pat_t[4] = CMD_WR; pat_a[4] = 32'd0;
        pat_t[5] = CMD_RD; pat_a[5] = 32'd1024;
        pat_t[6] = CMD_RD; pat_a[6] = 32'd1280;
        pat_t[7] = CMD_RD; pat_a[7] = 32'd1536;
        pat_t[8] = CMD_RD; pat_a[8] = 32'd1792;
        pat_t[9] = CMD_WR; pat_a[9] = 32'd256;
        for (int k = 0; k < 10 && ok; k++) begin
            next_cmd(1'b1, t, a, c, ok);
            chk("rw_type", 32'(t), 32'(pat_t[k]));
            chk("rw_addr", a, pat_a[k]);
        end
        @(negedge CLK);
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (20) @(negedge CLK);
        rd_idx = log_n;
        pulse(1'b0);
        rd_req = 1'b1;
        next_cmd(1'b1, t, a, c, ok);
        chk("rd_fs_type", 32'(t), 32'(CMD_RD));
        chk("rd_fs_addr", a, BUF_STEP);
        rd_req = 1'b0;

        // ---- write stream: stall with dropped request, frame start at accept of 1024
        do_reset();
        ready_en = 1'b0;
        wr_req   = 1'b1;
        release_reset();
        repeat (4) @(negedge CLK);
        wr_req = 1'b0;
        chk("stall_valid", 32'(cmd_valid), 1);
        chk("stall_type", 32'(cmd_type), 32'(CMD_WR));
        chk("stall_addr", 32'(cmd_addr), 0);
        repeat (3) @(negedge CLK);
        chk("stall_valid2", 32'(cmd_valid), 1);
        chk("stall_addr2", 32'(cmd_addr), 0);
        ready_en = 1'b1;
        next_cmd(1'b1, t, a, c, ok);
        chk("wr0_type", 32'(t), 32'(CMD_WR));
        chk("wr0_addr", a, 0);
        wr_req = 1'b1;
        for (int k = 1; k < 4; k++) begin
            next_cmd(1'b1, t, a, c, ok);
            chk("wr_type", 32'(t), 32'(CMD_WR));
            chk("wr_addr", a, 32'(k * 256));
        end
        got = 1'b0;
        for (int g = 0; g < 100 && !got; g++) begin
            @(negedge CLK);
            if (cmd_valid && cmd_ready && cmd_type == CMD_WR) begin
                got = 1'b1;
                chk("coll_accept_addr", 32'(cmd_addr), 1024);
                #1;
                wr_frame_start = 1'b1;
                @(posedge CLK);
                #2;
                wr_frame_start = 1'b0;
            end
        end
        chk("coll_seen", 32'(got), 1);
        @(negedge CLK);
        chk("coll_addr_held", 32'(cmd_addr), 1024);
        next_cmd(1'b1, t, a, c, ok);
        chk("coll_log_addr", a, 1024);
        next_cmd(1'b1, t, a, c, ok);
        chk("after_fs_type", 32'(t), 32'(CMD_WR));
        chk("after_fs_addr", a, BUF_STEP);
        wr_req = 1'b0;

        // ---- refresh starved by a burst that never completes
        do_reset();
        done_en = 1'b0;
        rd_req  = 1'b1;
        release_reset();
        wait_cyc(800);
        chk("overrun_early", 32'(ref_overrun), 0);
        wait_cyc(1570);
        chk("overrun_set", 32'(ref_overrun), 1);
        done_en = 1'b1;
        repeat (60) @(negedge CLK);
        chk("overrun_sticky", 32'(ref_overrun), 1);
        do_reset();
        release_reset();

`ifdef SDRAM_ARB_PINGPONG_EN
        // ---- double buffering: reader follows the buffer not being written
        do_reset();
        release_reset();
        pulse(1'b1);
        pulse(1'b1);
        pulse(1'b0);
        rd_idx = log_n;
        rd_req = 1'b1;
        next_cmd(1'b1, t, a, c, ok);
        chk("pp_rd_type", 32'(t), 32'(CMD_RD));
        chk("pp_rd_addr", a, 32'd524288);
        @(negedge CLK);
        rd_req = 1'b0;
        wr_req = 1'b1;
        next_cmd(1'b1, t, a, c, ok);
        chk("pp_wr_type", 32'(t), 32'(CMD_WR));
        chk("pp_wr_addr", a, 0);
        wr_req = 1'b0;
`endif

        repeat (5) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_frame_arbiter.md
Name: sdram_frame_arbiter

Overview:
- Schedules all accesses to the single shared SDRAM: camera write bursts, VGA read bursts, and periodic auto-refresh.
- Sits between the CMOS-capture write FIFO and VGA read FIFO on one side and the SDRAM command/burst controller on the other.
- Generates frame-linear burst addresses for both streams.
- Issues exactly one command at a time and waits for its completion.

Parameters:
ADDR_W, 22, word-address width to SDRAM controller
BURST_LEN, 256, words per read/write burst; address step per command
FRAME_WORDS, 307200, words per frame (640x480, 16-bit RGB565); must be a multiple of BURST_LEN
REF_PERIOD, 780, clocks between refresh requests (7.8 us at 100 MHz)
READ_MAX, 4, max consecutive read grants while a write is pending

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
wr_req  in  1  level: camera FIFO holds >= BURST_LEN words
rd_req  in  1  level: VGA FIFO has room for >= BURST_LEN words
wr_frame_start  in  1  pulse: camera VSYNC, restart write pointer
rd_frame_start  in  1  pulse: VGA VSYNC, restart read pointer
cmd_valid  out  1  command presented to SDRAM controller
cmd_type  out  2  0=read, 1=write, 2=refresh
cmd_addr  out  ADDR_W  burst start word address (0 for refresh)
cmd_ready  in  1  controller accepts command this cycle
cmd_done  in  1  pulse: command finished
wr_busy  out  1  write burst in progress (camera FIFO drains)
rd_busy  out  1  read burst in progress (VGA FIFO fills)
ref_overrun  out  1  sticky: refresh period expired with refresh still pending

Behaviour:
- Reset: all outputs 0; state IDLE; wr_addr=rd_addr=0; refresh counter=0; ref_pending=0; read-streak counter=0.
- FSM IDLE -> ISSUE -> BUSY -> IDLE.
- IDLE:
  - Priority: ref_pending > rd_req > wr_req.
  - Exception: if wr_req and the read streak has reached READ_MAX, write wins over read.
  - If nothing is pending, stay in IDLE.
  - On a decision, latch cmd_type and cmd_addr; go to ISSUE next cycle.
- ISSUE:
  - cmd_valid=1; type and address held stable until cmd_ready.
  - Accept when cmd_valid and cmd_ready are both high in the same cycle; go to BUSY.
- On accept:
  - Read: rd_addr += BURST_LEN; streak += 1.
  - Write: wr_addr += BURST_LEN; streak = 0.
  - Refresh: ref_pending = 0.
  - A pointer reaching FRAME_WORDS wraps to 0.
- BUSY:
  - cmd_valid=0; wr_busy or rd_busy=1 according to the latched type (neither for refresh).
  - On cmd_done, deassert the busy flag in the same cycle; go to IDLE.
  - Minimum gap between commands is 2 cycles.
- Refresh counter:
  - Free-runs 0..REF_PERIOD-1.
  - At wrap, sets ref_pending.
  - If ref_pending is already 1 at wrap, sets ref_overrun (cleared only by reset).
- Frame starts:
  - wr_frame_start forces wr_addr=0 and rd_frame_start forces rd_addr=0, in any state.
  - A frame start takes precedence over a same-cycle post-accept increment.
  - An already-latched cmd_addr is unaffected.
- cmd_done outside BUSY: ignored.
- Requests dropping during ISSUE: the command is still issued (no retraction).
- Reset asserted mid-burst: immediate return to reset state. The SDRAM controller is reset by the same RSTn.

Optional Feature:
- Macro SDRAM_ARB_PINGPONG_EN.
- When defined:
  - Two frame buffers; address bit FRAME_SEL = ceil(log2(FRAME_WORDS)) selects the buffer.
  - Write buffer toggles on each wr_frame_start.
  - rd_frame_start latches the read buffer as the buffer not currently being written.
  - cmd_addr = {buffer bit, pointer}.
- When undefined: single buffer; buffer bit always 0.

Decomposition:
- Package sdram_arb_pkg: cmd_type encodings (CMD_RD=0, CMD_WR=1, CMD_REF=2), FSM state encodings, and a function computing the buffer-bit index from FRAME_WORDS.
- One sub-module, sdram_refresh_timer: counter, ref_pending, ref_overrun. Input is a clear pulse on refresh accept.

Test Plan:
- Reset, then hold only rd_req with cmd_ready=1 and cmd_done 3 cycles after accept -> cmd_type=0 with addrs 0, 256, 512...; wrap to 0 after addr 307,200-256=306,944.
- wr_req and rd_req held high continuously -> grant pattern R,R,R,R,W repeating; rd_busy/wr_busy match the granted type.
- Run with REF_PERIOD=780 while traffic is pending -> a refresh is issued at the first IDLE after counter wrap, preempting pending read/write.
- Hold cmd_done low for more than 2×REF_PERIOD -> ref_overrun=1 and stays 1 until RSTn.
- Pulse wr_frame_start in the same cycle as a write accept at wr_addr=1024 -> cmd_addr stays 1024; the next write goes to 0.
- With SDRAM_ARB_PINGPONG_EN: two wr_frame_start pulses, then rd_frame_start -> read addresses carry the buffer bit opposite to the current write buffer.
